fs_with_d38: RTL and testbench

- 1-bit full subtractor computing a − b − c, where c is the borrow-in.
- Built from a 3-to-8 line decoder: the inputs {a,b,c} drive the decoder, and diff/borrow are ORs of the selected minterms.
- Outputs are registered on one clock with synchronous active-high reset.
- Leaf arithmetic cell, used standalone or chained into ripple subtractors.

---
 rtl/fs_with_d38.sv | 62 ++++++
 tb/tb_fs_with_d38.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fs_with_d38.sv
// 1-bit full subtractor a - b - c built from a one-hot 3-to-8 decoder.
// Difference, borrow and the decoder word are registered on one clock.

module fs_with_d38_dec (
    input  logic [2:0] sel,
    output logic [7:0] d
);

    always_comb begin
        d = 8'h00;
        unique case (sel)
            3'd0: d = 8'h01;
            3'd1: d = 8'h02;
            3'd2: d = 8'h04;
            3'd3: d = 8'h08;
            3'd4: d = 8'h10;
            3'd5: d = 8'h20;
            3'd6: d = 8'h40;
            3'd7: d = 8'h80;
            default: d = 8'h00;
        endcase
    end

endmodule

module fs_with_d38 (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic       diff,
    output logic       borrow,
    output logic [7:0] dec_out
);

    logic [7:0] d;
    logic       diff_n;
    logic       borrow_n;

    fs_with_d38_dec u_dec (
        .sel ({a, b, c}),
        .d   (d)
    );

    // Minterm sums: odd-parity rows for diff, negative results for borrow
    assign diff_n   = d[1] | d[2] | d[4] | d[7];
    assign borrow_n = d[1] | d[2] | d[3] | d[7];

    always_ff @(posedge clk) begin
        if (rst) begin
            diff    <= 1'b0;
            borrow  <= 1'b0;
            dec_out <= 8'h00;
        end else begin
            diff    <= diff_n;
            borrow  <= borrow_n;
            dec_out <= d;
        end
    end

endmodule

// File: tb/tb_fs_with_d38.sv
// Bench for fs_with_d38: arithmetic reference model checked every cycle,
// plus directed literal expectations from the truth table.

module tb_fs_with_d38;

    logic       clk;
    logic       rst;
    logic       a;
    logic       b;
    logic       c;
    logic       diff;
    logic       borrow;
    logic [7:0] dec_out;

    int errors = 0;
    int checks = 0;

    logic       m_valid = 1'b0;
    logic       m_diff;
    logic       m_bor;
    logic [7:0] m_dec;
    logic       rnd_phase = 1'b0;

    // Truth-table columns, bit i = row {a,b,c}==i
    logic [7:0] tt_diff = 8'h96;
    logic [7:0] tt_bor  = 8'h8E;

    fs_with_d38 dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .c       (c),
        .diff    (diff),
        .borrow  (borrow),
        .dec_out (dec_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: evaluate a - b - c as an integer and split it
    always @(posedge clk) begin
        int r;
        logic [7:0] one;
        one = 8'h01;
        r = int'(a) - int'(b) - int'(c);
        if (rst) begin
            m_diff <= 1'b0;
            m_bor  <= 1'b0;
            m_dec  <= 8'h00;
        end else begin
            m_diff <= ((r & 1) != 0);
            m_bor  <= (r < 0);
            m_dec  <= one << {a, b, c};
        end
        m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_diff", int'(diff), int'(m_diff));
            chk("model_borrow", int'(borrow), int'(m_bor));
            chk("model_dec", int'(dec_out), int'(m_dec));
            if (rnd_phase)
                chk("onehot", $countones(dec_out), 1);
        end
    end

    task automatic cyc(input logic r, input logic [2:0] abc);
        rst = r;
        {a, b, c} = abc;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string tag, input logic d, input logic bo,
                       input logic [7:0] dv);
        chk({tag, "_diff"}, int'(diff), int'(d));
        chk({tag, "_borrow"}, int'(borrow), int'(bo));
        chk({tag, "_dec"}, int'(dec_out), int'(dv));
    endtask

    initial begin
        int lhs;
        int rhs;
        logic [7:0] one;
        one = 8'h01;
        rst = 1'b1;
        {a, b, c} = 3'b111;

        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 3'b111);
            lit("reset", 1'b0, 1'b0, 8'h00);
        end
        cyc(1'b0, 3'b111);
        lit("release", 1'b1, 1'b1, 8'h80);

        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 3'(i));
            lit("sweep", tt_diff[i], tt_bor[i], one << i);
            lhs = int'(diff) - 2 * int'(borrow);
            rhs = int'(a) - int'(b) - int'(c);
            chk("identity", lhs, rhs);
            if (i == 5) begin
                cyc(1'b1, 3'b101);
                lit("midreset", 1'b0, 1'b0, 8'h00);
                cyc(1'b0, 3'b110);
                lit("postreset", 1'b0, 1'b0, 8'h40);
            end else begin
                cyc(1'b0, 3'(i));
            end
        end

        cyc(1'b0, 3'b011);
        lit("row3", 1'b0, 1'b1, 8'h08);
        cyc(1'b0, 3'b100);
        lit("row4", 1'b1, 1'b0, 8'h10);

        cyc(1'b0, 3'b000);
        lit("lat_base", 1'b0, 1'b0, 8'h01);
        {a, b, c} = 3'b001;
        #2;
        lit("lat_hold", 1'b0, 1'b0, 8'h01);
        @(posedge clk);
        #1;
        lit("lat_load", 1'b1, 1'b1, 8'h02);

        rnd_phase = 1'b1;
        for (int k = 0; k < 200; k++)
            cyc(1'b0, 3'($urandom_range(0, 7)));
        @(negedge clk);
        rnd_phase = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
